// File: rtl/el_display_pkg.sv
// Shared EL display constants: character grid geometry, RAM address width,
// fill/substitute bytes, control codes and the character RAM writer state encoding.
package el_display_pkg;

    localparam int COLS   = 40;
    localparam int ROWS   = 32;
    localparam int ADDR_W = 11;
    localparam int CELLS  = COLS * ROWS;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 5;

    localparam logic [7:0] CLEAR_CHAR = 8'h20;
    localparam logic [7:0] SUBST_CHAR = 8'h3F;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    localparam logic [COL_W-1:0]  LAST_COL       = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW       = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_CLR_END    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] SCREEN_CLR_END = ADDR_W'(CELLS);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLR_ROW,
        CLR_SCREEN
    } wr_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

    // row*40 as two shifts, kept in ADDR_W bits so no product bit is lost.
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        return (r << 5) + (r << 3);
    endfunction

    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] row);
        return (row == LAST_ROW) ? '0 : row + ROW_W'(1);
    endfunction

endpackage

// File: rtl/char_ram_writer.sv
// Writer side of the character RAM: takes an ASCII byte stream over valid/ready,
// tracks the text cursor and issues single-cycle RAM writes, row clears and screen clears.
module char_ram_writer
    import el_display_pkg::*;
(
    input  logic              in_main_clock,
    input  logic              in_reset_n,
    input  logic              in_char_valid,
    input  logic [7:0]        in_char_data,
    output logic              out_char_ready,
    output logic [ADDR_W-1:0] out_ram_wr_address,
    output logic [7:0]        out_ram_wr_data,
    output logic              out_ram_we,
    output logic [COL_W-1:0]  out_cursor_x,
    output logic [ROW_W-1:0]  out_cursor_y,
    output logic              out_busy
);

    wr_state_t         state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [COL_W-1:0]  x_nxt;
    logic [ROW_W-1:0]  y_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [7:0]        data_nxt;
    logic              ready_nxt;
    logic              busy_nxt;

    logic              accept;
    logic [ADDR_W-1:0] row_base_addr;
    logic [ADDR_W-1:0] cursor_addr;

    assign accept        = in_char_valid & out_char_ready;
    assign row_base_addr = row_base(out_cursor_y);
    assign cursor_addr   = row_base_addr + ADDR_W'(out_cursor_x);

    always_ff @(posedge in_main_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state              <= CLR_SCREEN;
            clr_cnt            <= '0;
            out_cursor_x       <= '0;
            out_cursor_y       <= '0;
            out_ram_we         <= 1'b0;
            out_ram_wr_address <= '0;
            out_ram_wr_data    <= CLEAR_CHAR;
            out_char_ready     <= 1'b0;
            out_busy           <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values on the same edge.
            state              <= state_nxt;
            clr_cnt            <= clr_cnt_nxt;
            out_cursor_x       <= x_nxt;
            out_cursor_y       <= y_nxt;
            out_ram_we         <= we_nxt;
            out_ram_wr_address <= addr_nxt;
            out_ram_wr_data    <= data_nxt;
            out_char_ready     <= ready_nxt;
            out_busy           <= busy_nxt;
        end
    end

    always_comb begin
        // NOTE: every next-value signal gets a default first, so no branch leaves one unassigned (no latch).
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        x_nxt       = out_cursor_x;
        y_nxt       = out_cursor_y;
        we_nxt      = 1'b0;
        addr_nxt    = out_ram_wr_address;
        data_nxt    = out_ram_wr_data;
        ready_nxt   = out_char_ready;
        busy_nxt    = out_busy;

        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                if (accept) begin
                    if (is_printable(in_char_data) || in_char_data[7]) begin
                        state_nxt = WRITE;
                        we_nxt    = 1'b1;
                        addr_nxt  = cursor_addr;
                        data_nxt  = in_char_data[7] ? SUBST_CHAR : in_char_data;
                        ready_nxt = 1'b0;
                    end else begin
                        case (in_char_data)
                            CC_CR: x_nxt = '0;
                            CC_LF: begin
                                x_nxt       = '0;
                                y_nxt       = next_row(out_cursor_y);
                                state_nxt   = CLR_ROW;
                                clr_cnt_nxt = '0;
                                ready_nxt   = 1'b0;
                                busy_nxt    = 1'b1;
                            end
                            CC_BS: begin
                                if (out_cursor_x != '0) x_nxt = out_cursor_x - COL_W'(1);
                            end
                            CC_FF: begin
                                x_nxt       = '0;
                                y_nxt       = '0;
                                state_nxt   = CLR_SCREEN;
                                clr_cnt_nxt = '0;
                                ready_nxt   = 1'b0;
                                busy_nxt    = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            WRITE: begin
                if (out_cursor_x < LAST_COL) begin
                    x_nxt     = out_cursor_x + COL_W'(1);
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    // Wrapping past the last column blanks the row the cursor lands on.
                    x_nxt       = '0;
                    y_nxt       = next_row(out_cursor_y);
                    state_nxt   = CLR_ROW;
                    clr_cnt_nxt = '0;
                    ready_nxt   = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end

            CLR_ROW: begin
                if (clr_cnt == ROW_CLR_END) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    we_nxt      = 1'b1;
                    addr_nxt    = row_base_addr + clr_cnt;
                    data_nxt    = CLEAR_CHAR;
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end

            CLR_SCREEN: begin
                if (clr_cnt == SCREEN_CLR_END) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    we_nxt      = 1'b1;
                    addr_nxt    = clr_cnt;
                    data_nxt    = CLEAR_CHAR;
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_char_ram_writer.sv
// Self-checking bench for char_ram_writer: directed scenarios plus random bytes,
// compared against a character-grid reference model (cursor, expected write stream, screen image).
module tb_char_ram_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        ready, we, busy;
    logic [10:0] addr;
    logic [7:0]  wdata;
    logic [5:0]  cur_x;
    logic [4:0]  cur_y;

    always #5 clk = ~clk;

    char_ram_writer dut (
        .in_main_clock      (clk),
        .in_reset_n         (rst_n),
        .in_char_valid      (valid),
        .in_char_data       (data_in),
        .out_char_ready     (ready),
        .out_ram_wr_address (addr),
        .out_ram_wr_data    (wdata),
        .out_ram_we         (we),
        .out_cursor_x       (cur_x),
        .out_cursor_y       (cur_y),
        .out_busy           (busy)
    );

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        wr_q[$];
    wr_t        exp_q[$];
    logic [7:0] dut_mem[1280];
    logic [7:0] model_mem[1280];
    int         cyc = 0;
    int         oob = 0;
    int         idle_we = 0;
    int         errors = 0;
    int         checks = 0;
    int         mcx = 0;
    int         mcy = 0;

    // Write monitor: records every RAM write just after the edge that issued it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (we === 1'b1) begin
            wr_q.push_back('{addr, wdata, cyc});
            if (addr < 11'd1280) dut_mem[addr] = wdata;
            else oob = oob + 1;
            if (ready !== 1'b0) idle_we = idle_we + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: 40x32 grid, cursor and the ordered list of RAM writes each byte causes.
    task automatic push_exp(input int a, input logic [7:0] d);
        exp_q.push_back('{11'(a), d, 0});
        model_mem[a] = d;
    endtask

    task automatic model_clear(input int base, input int n);
        for (int i = 0; i < n; i++) push_exp(base + i, 8'h20);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if ((b >= 8'h20 && b <= 8'h7E) || b >= 8'h80) begin
            push_exp(mcy * 40 + mcx, (b >= 8'h80) ? 8'h3F : b);
            if (mcx < 39) mcx = mcx + 1;
            else begin
                mcx = 0;
                mcy = (mcy + 1) % 32;
                model_clear(mcy * 40, 40);
            end
        end else if (b == 8'h0A) begin
            mcx = 0;
            mcy = (mcy + 1) % 32;
            model_clear(mcy * 40, 40);
        end else if (b == 8'h0D) begin
            mcx = 0;
        end else if (b == 8'h08) begin
            if (mcx > 0) mcx = mcx - 1;
        end else if (b == 8'h0C) begin
            mcx = 0;
            mcy = 0;
            model_clear(0, 1280);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        valid   = 1'b1;
        data_in = b;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready for byte %02h", b), ready, 1);
        acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        valid   = 1'b0;
        data_in = 8'($urandom);
        model_byte(b);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " idle"}, ready, 1);
    endtask

    task automatic compare_stream(input string tag);
        int bad;
        int n;
        bad = -1;
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        check({tag, " write count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            if (bad < 0 && (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data)) bad = i;
        if (bad >= 0)
            check($sformatf("%s write#%0d {addr,data}", tag, bad),
                  {wr_q[bad].addr, wr_q[bad].data}, {exp_q[bad].addr, exp_q[bad].data});
        check({tag, " cursor_x"}, cur_x, mcx);
        check({tag, " cursor_y"}, cur_y, mcy);
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic do_byte(input logic [7:0] b, input string tag);
        int acc;
        send_byte(b, acc);
        wait_idle(tag);
        compare_stream(tag);
    endtask

    initial begin
        int         acc;
        int         n;
        int         r;
        int         diffs;
        logic [7:0] b;

        for (int i = 0; i < 1280; i++) begin
            dut_mem[i]   = 8'h00;
            model_mem[i] = 8'h00;
        end

        // 1. Reset values, then the full-screen clear after release.
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset we", we, 0);
        check("reset addr", addr, 0);
        check("reset data", wdata, 8'h20);
        check("reset ready", ready, 0);
        check("reset busy", busy, 1);
        check("reset cursor_x", cur_x, 0);
        check("reset cursor_y", cur_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mcx = 0;
        mcy = 0;
        model_clear(0, 1280);
        @(posedge clk);
        #1;
        check("t1 first clear we", we, 1);
        check("t1 first clear addr", addr, 0);
        check("t1 ready during clear", ready, 0);
        check("t1 busy during clear", busy, 1);
        wait_idle("t1");
        if (wr_q.size() == 1280) check("t1 clear contiguous", wr_q[1279].cyc - wr_q[0].cyc, 1279);
        check("t1 busy after clear", busy, 0);
        compare_stream("t1");

        // 2. 'A' at (0,0): write on the cycle after acceptance, ready back one cycle later.
        send_byte(8'h41, acc);
        check("t2 we", we, 1);
        check("t2 addr", addr, 0);
        check("t2 data", wdata, 8'h41);
        check("t2 ready low", ready, 0);
        @(posedge clk);
        #1;
        check("t2 ready back", ready, 1);
        check("t2 we dropped", we, 0);
        check("t2 cursor_x", cur_x, 1);
        wait_idle("t2");
        compare_stream("t2");

        // 3. Last column of row 5: char write then row 6 cleared.
        for (int i = 0; i < 5; i++) do_byte(8'h0A, $sformatf("t3 lf%0d", i));
        for (int i = 0; i < 39; i++) send_byte(8'($urandom_range(32, 126)), acc);
        wait_idle("t3 fill");
        compare_stream("t3 fill");
        send_byte(8'h42, acc);
        wait_idle("t3");
        if (wr_q.size() == 41) begin
            check("t3 char addr", wr_q[0].addr, 239);
            check("t3 char data", wr_q[0].data, 8'h42);
            check("t3 clear first addr", wr_q[1].addr, 240);
            check("t3 clear last addr", wr_q[40].addr, 279);
            check("t3 clear contiguous", wr_q[40].cyc - wr_q[1].cyc, 39);
        end
        compare_stream("t3");

        // 4. LF on the last row wraps to row 0; CR writes nothing.
        for (int i = 0; i < 25; i++) do_byte(8'h0A, $sformatf("t4 lf%0d", i));
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(32, 126)), acc);
        wait_idle("t4 fill");
        compare_stream("t4 fill");
        send_byte(8'h0A, acc);
        wait_idle("t4 wrap");
        if (wr_q.size() == 40) begin
            check("t4 clear first addr", wr_q[0].addr, 0);
            check("t4 clear last addr", wr_q[39].addr, 39);
        end
        compare_stream("t4 wrap");
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(32, 126)), acc);
        wait_idle("t4 cr fill");
        compare_stream("t4 cr fill");
        do_byte(8'h0D, "t4 cr");

        // 5. BS at column 0, high byte substitution, BS mid-row, form feed.
        do_byte(8'h0A, "t5 lf0");
        do_byte(8'h0A, "t5 lf1");
        do_byte(8'h08, "t5 bs col0");
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(32, 126)), acc);
        wait_idle("t5 fill");
        compare_stream("t5 fill");
        send_byte(8'hC8, acc);
        wait_idle("t5 subst");
        if (wr_q.size() == 1) begin
            check("t5 subst addr", wr_q[0].addr, 84);
            check("t5 subst data", wr_q[0].data, 8'h3F);
        end
        compare_stream("t5 subst");
        do_byte(8'h08, "t5 bs");
        send_byte(8'h0C, acc);
        wait_idle("t5 ff");
        if (wr_q.size() == 1280) check("t5 ff contiguous", wr_q[1279].cyc - wr_q[0].cyc, 1279);
        compare_stream("t5 ff");

        // Valid offered and withdrawn while busy: must not transfer.
        send_byte(8'h0A, acc);
        repeat (2) @(negedge clk);
        valid   = 1'b1;
        data_in = 8'h0C;
        repeat (3) begin
            @(negedge clk);
            check("drop ready low", ready, 0);
        end
        valid = 1'b0;
        wait_idle("drop");
        compare_stream("drop");

        // Valid held while busy: accepted exactly once, only after the clear.
        send_byte(8'h0A, acc);
        send_byte(8'h55, acc);
        wait_idle("hold");
        if (wr_q.size() == 41) begin
            check("hold accept after clear", (wr_q[40].cyc - wr_q[39].cyc) >= 2, 1);
            check("hold write at accept", wr_q[40].cyc, acc);
        end
        compare_stream("hold");

        // 6. Reset in the middle of a row clear.
        send_byte(8'h0A, acc);
        n = 0;
        while (wr_q.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6 clear started", wr_q.size() >= 5, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async we", we, 0);
        check("t6 async busy", busy, 1);
        check("t6 async ready", ready, 0);
        check("t6 async addr", addr, 0);
        check("t6 async cursor_y", cur_y, 0);
        wr_q.delete();
        exp_q.delete();
        mcx = 0;
        mcy = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear(0, 1280);
        wait_idle("t6");
        compare_stream("t6");

        // Random byte stream, compared at idle points.
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) b = 8'($urandom_range(32, 126));
            else if (r < 68) b = 8'($urandom_range(128, 255));
            else if (r < 80) b = 8'h0A;
            else if (r < 86) b = 8'h0D;
            else if (r < 92) b = 8'h08;
            else if (r < 98) begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0A || b == 8'h0C || b == 8'h0D || b == 8'h08) b = 8'h7F;
            end else b = 8'h0C;
            send_byte(b, acc);
            if ($urandom_range(0, 1) == 1) begin
                wait_idle($sformatf("rnd%0d", i));
                compare_stream($sformatf("rnd%0d", i));
            end
        end
        wait_idle("rnd end");
        compare_stream("rnd end");

        diffs = 0;
        for (int i = 0; i < 1280; i++) if (dut_mem[i] !== model_mem[i]) diffs++;
        check("screen image differences", diffs, 0);
        check("addresses out of range", oob, 0);
        check("writes while ready", idle_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
